image_loader: RTL and testbench

- Input-side counterpart to the network's result path: receives a framed byte stream of one 28x28 image, writes the quantized pixels into the network's input pixel memory, then pulses Compute and holds off new frames until the network reports done.
- Sits between the byte source (UART receiver / host link) and neural_network, replacing the manual button-driven Compute.

---
 rtl/image_loader.sv | 128 ++++++++++++
 tb/tb_image_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_loader.sv
// Framed byte-stream loader: strips the header, writes NUM_PIXELS quantized pixels
// into the network's input memory, then starts the network and waits for it to finish.
module image_loader #(
    parameter int          NUM_PIXELS = 784,
    parameter int          PIXEL_W    = 8,
    parameter logic [7:0]  HEADER     = 8'hA5,
    parameter int          TIMEOUT    = 100000
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [7:0]                    Rx_Data,
    input  logic                          Rx_Valid,
    output logic                          Rx_Ready,
    output logic [$clog2(NUM_PIXELS)-1:0] Pixel_Addr,
    output logic [PIXEL_W-1:0]            Pixel_Data,
    output logic                          Pixel_We,
    output logic                          Compute,
    input  logic                          NN_Done,
    output logic                          Busy,
    output logic                          Frame_Err
);

    localparam int ADDR_W = $clog2(NUM_PIXELS);
    localparam int TMO_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              accept;
    logic              last_pixel;
    logic              tmo_hit;

    assign accept     = Rx_Valid && Rx_Ready;
    assign last_pixel = (pix_cnt == ADDR_W'(NUM_PIXELS - 1));
    assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An accept in LOAD always beats a simultaneous timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept && (Rx_Data == HEADER)) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (last_pixel) begin
                        next_state = S_START;
                    end
                end else if (tmo_hit) begin
                    next_state = S_IDLE;
                end
            end
            S_START: next_state = S_WAIT;
            S_WAIT: begin
                if (NN_Done) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        Rx_Ready = (state == S_IDLE) || (state == S_LOAD);
        Busy     = (state != S_IDLE);
    end

    // Compute is delayed one cycle from START so the final pixel write lands first.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_cnt    <= '0;
            tmo_cnt    <= '0;
            Pixel_We   <= 1'b0;
            Pixel_Addr <= '0;
            Pixel_Data <= '0;
            Compute    <= 1'b0;
            Frame_Err  <= 1'b0;
        end else begin
            Pixel_We  <= 1'b0;
            Frame_Err <= 1'b0;
            Compute   <= (state == S_START);
            case (state)
                S_IDLE: begin
                    if (accept && (Rx_Data == HEADER)) begin
                        pix_cnt <= '0;
                        tmo_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        Pixel_We   <= 1'b1;
                        Pixel_Addr <= pix_cnt;
                        Pixel_Data <= Rx_Data[7 -: PIXEL_W];
                        tmo_cnt    <= '0;
                        if (!last_pixel) begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        Frame_Err <= 1'b1;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Directed bench: two loaders (8-bit and 4-bit pixels, short timeout) driven by the
// same byte stream, each output compared to hand-derived expectations.
module tb_image_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       nn_done;

    logic       ready_a, we_a, compute_a, busy_a, err_a;
    logic [9:0] addr_a;
    logic [7:0] data_a;
    logic       ready_b, we_b, compute_b, busy_b, err_b;
    logic [9:0] addr_b;
    logic [3:0] data_b;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    image_loader #(.PIXEL_W(8), .TIMEOUT(16)) dut_a (
        .Clk(clk), .Reset(reset), .Rx_Data(rx_data), .Rx_Valid(rx_valid),
        .Rx_Ready(ready_a), .Pixel_Addr(addr_a), .Pixel_Data(data_a), .Pixel_We(we_a),
        .Compute(compute_a), .NN_Done(nn_done), .Busy(busy_a), .Frame_Err(err_a)
    );

    image_loader #(.PIXEL_W(4), .TIMEOUT(16)) dut_b (
        .Clk(clk), .Reset(reset), .Rx_Data(rx_data), .Rx_Valid(rx_valid),
        .Rx_Ready(ready_b), .Pixel_Addr(addr_b), .Pixel_Data(data_b), .Pixel_We(we_b),
        .Compute(compute_b), .NN_Done(nn_done), .Busy(busy_b), .Frame_Err(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [7:0] data);
        rx_valid = valid;
        rx_data  = data;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic rdy, input logic busy,
                              input logic we, input logic cmp, input logic err);
        check_output({tag, "/ready_a"},   32'(ready_a),   32'(rdy));
        check_output({tag, "/ready_b"},   32'(ready_b),   32'(rdy));
        check_output({tag, "/busy_a"},    32'(busy_a),    32'(busy));
        check_output({tag, "/busy_b"},    32'(busy_b),    32'(busy));
        check_output({tag, "/we_a"},      32'(we_a),      32'(we));
        check_output({tag, "/we_b"},      32'(we_b),      32'(we));
        check_output({tag, "/compute_a"}, 32'(compute_a), 32'(cmp));
        check_output({tag, "/compute_b"}, 32'(compute_b), 32'(cmp));
        check_output({tag, "/err_a"},     32'(err_a),     32'(err));
        check_output({tag, "/err_b"},     32'(err_b),     32'(err));
    endtask

    task automatic check_write(input int k, input logic [7:0] v);
        check_ctrl($sformatf("write%0d", k), (k != 783), 1'b1, 1'b1, 1'b0, 1'b0);
        check_output($sformatf("addr_a%0d", k), 32'(addr_a), 32'(k));
        check_output($sformatf("addr_b%0d", k), 32'(addr_b), 32'(k));
        check_output($sformatf("data_a%0d", k), 32'(data_a), 32'(v));
        check_output($sformatf("data_b%0d", k), 32'(data_b), 32'(v[7:4]));
    endtask

    function automatic logic [7:0] pix_val(input int mode, input int k);
        logic [7:0] v;
        v = 8'(k);
        case (mode)
            1: begin
                if (k == 5)      v = 8'hF3;
                else if (k == 6) v = 8'hA5;
                else             v = 8'(k * 7 + 3);
            end
            2: v = 8'(k) ^ 8'h5A;
            default: ;
        endcase
        return v;
    endfunction

    task automatic send_header();
        apply_stimulus(1'b1, 8'hA5);
        tick();
        check_ctrl("header", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pixels(input int mode, input int first, input int last,
                               input int max_gap, input bit noisy);
        int         gap;
        logic [7:0] v;
        for (int k = first; k <= last; k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                apply_stimulus(1'b0, 8'h00);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check_ctrl("gap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                end
            end
            nn_done = noisy && (k % 2 == 1) && (k != last);
            v = pix_val(mode, k);
            apply_stimulus(1'b1, v);
            tick();
            check_write(k, v);
        end
        nn_done = 1'b0;
        apply_stimulus(1'b0, 8'h00);
    endtask

    task automatic finish_frame(input int wait_cycles);
        tick();
        check_ctrl("compute", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < wait_cycles; i++) begin
            tick();
            check_ctrl("wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        nn_done = 1'b1;
        tick();
        check_ctrl("done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nn_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        nn_done = 1'b0;
        apply_stimulus(1'b0, 8'h00);
        repeat (3) tick();
        check_ctrl("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("reset/addr_a", 32'(addr_a), 32'd0);
        check_output("reset/data_a", 32'(data_a), 32'd0);
        check_output("reset/data_b", 32'(data_b), 32'd0);
        reset = 1'b0;
        tick();
        check_ctrl("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Plain frame, back-to-back bytes
        send_header();
        send_pixels(0, 0, 783, 0, 1'b0);
        finish_frame(5);

        // Junk bytes in IDLE are dropped, even with NN_Done high
        nn_done = 1'b1;
        apply_stimulus(1'b1, 8'h00);
        tick();
        check_ctrl("junk0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h3C);
        tick();
        check_ctrl("junk1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nn_done = 1'b0;
        send_header();
        send_pixels(1, 0, 783, 0, 1'b0);
        finish_frame(2);

        // Random gaps below the timeout, NN_Done toggling during LOAD
        send_header();
        send_pixels(2, 0, 783, 8, 1'b1);
        finish_frame(0);

        // Byte arriving on the timeout cycle wins, then a real stall aborts
        send_header();
        send_pixels(0, 0, 8, 0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check_ctrl("gap15", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        apply_stimulus(1'b1, pix_val(0, 9));
        tick();
        check_write(9, pix_val(0, 9));
        apply_stimulus(1'b0, 8'h00);
        for (int i = 0; i < 15; i++) begin
            tick();
            check_ctrl("stall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_ctrl("timeout", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_ctrl("after_timeout", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_header();
        send_pixels(2, 0, 783, 0, 1'b0);
        finish_frame(1);

        // Reset in the middle of LOAD cancels the pending write
        send_header();
        send_pixels(0, 0, 399, 0, 1'b0);
        apply_stimulus(1'b1, pix_val(0, 400));
        reset = 1'b1;
        tick();
        check_ctrl("rst_load", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("rst_load/addr_a", 32'(addr_a), 32'd0);
        reset = 1'b0;
        apply_stimulus(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ctrl("rst_load_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset while waiting on the network
        send_header();
        send_pixels(0, 0, 783, 0, 1'b0);
        tick();
        check_ctrl("compute2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_ctrl("wait2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check_ctrl("rst_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_ctrl("rst_wait_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
